// File: rtl/down_timer_pkg.sv
// Shared types and defaults for the down-timer controller and its counter core.
package down_timer_pkg;

    // Default counter width in bits
    localparam int DEFAULT_WIDTH = 4;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_count_core.sv
// Loadable synchronous down counter built from T flip-flops.
// Bit 0 always toggles; bit i toggles when every lower bit is zero (borrow ripple).
// Load has priority over enable. The zero flag is a plain decode of the count.
module down_count_core
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             zero
);

    logic [WIDTH-1:0] toggle;

    // Toggle terms: a bit flips when all less significant bits are 0
    always_comb begin
        toggle[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            toggle[i] = toggle[i-1] & ~q[i-1];
        end
    end

    // Counter register: load wins over decrement
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (enable) begin
            q <= q ^ toggle;
        end
    end

    assign zero = (q == '0);

endmodule

// File: rtl/down_timer_ctrl.sv
// Programmable countdown timer controller: sequences the down-counter core
// through load, decrement and terminal count, in one-shot or auto-reload mode,
// with pause and abort. All outputs come straight from registers.
module down_timer_ctrl
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             periodic,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             ready,
    output logic             tc_pulse,
    output logic             done
);

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic             mode;

    logic             core_load;
    logic             core_en;
    logic [WIDTH-1:0] core_din;
    logic             zero;

    down_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (core_load),
        .enable   (core_en),
        .load_val (core_din),
        .q        (count),
        .zero     (zero)
    );

    // Counter command decode: load on start, clear on abort, reload at terminal
    // count in periodic mode, otherwise decrement unless paused or at zero
    always_comb begin
        core_load = 1'b0;
        core_en   = 1'b0;
        core_din  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    core_load = 1'b1;
                    core_din  = load_val;
                end
            end
            RUN: begin
                if (abort) begin
                    core_load = 1'b1;
                    core_din  = '0;
                end else if (!pause) begin
                    if (!zero) begin
                        core_en = 1'b1;
                    end else if (mode) begin
                        core_load = 1'b1;
                        core_din  = reload;
                    end
                end
            end
            default: begin
                core_load = 1'b0;
            end
        endcase
    end

    // Sequencing FSM with reload/mode capture and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            reload   <= '0;
            mode     <= 1'b0;
            tc_pulse <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ready    <= 1'b1;
        end else begin
            tc_pulse <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        reload <= load_val;
                        mode   <= periodic;
                        state  <= RUN;
                        busy   <= 1'b1;
                        ready  <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end else if (!pause && zero) begin
                        tc_pulse <= 1'b1;
                        if (!mode) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_timer_ctrl.sv
// Scoreboard bench for down_timer_ctrl: stimulus pushes the expected post-edge
// output vector for every cycle it drives; a monitor pops and compares after
// each rising edge.
module tb_down_timer_ctrl;
    import down_timer_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         periodic = 1'b0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] count;
    logic         busy;
    logic         ready;
    logic         tc_pulse;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string        name;
        logic [W-1:0] count;
        logic         busy;
        logic         ready;
        logic         tc;
        logic         done;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t rst_e;

    down_timer_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .load_val (load_val),
        .periodic (periodic),
        .pause    (pause),
        .abort    (abort),
        .count    (count),
        .busy     (busy),
        .ready    (ready),
        .tc_pulse (tc_pulse),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input exp_t e);
        logic [W+3:0] act;
        logic [W+3:0] req;
        act = {count, busy, ready, tc_pulse, done};
        req = {e.count, e.busy, e.ready, e.tc, e.done};
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got count=%0d busy=%b ready=%b tc=%b done=%b, expected count=%0d busy=%b ready=%b tc=%b done=%b",
                     e.name, count, busy, ready, tc_pulse, done,
                     e.count, e.busy, e.ready, e.tc, e.done);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic step(input logic s, input int lv, input logic per, input logic pz,
                        input logic ab, input int ec, input logic eb, input logic er,
                        input logic et, input logic ed, input string nm);
        exp_t e;
        @(negedge clk);
        start    = s;
        load_val = lv[W-1:0];
        periodic = per;
        pause    = pz;
        abort    = ab;
        e.name  = nm;
        e.count = ec[W-1:0];
        e.busy  = eb;
        e.ready = er;
        e.tc    = et;
        e.done  = ed;
        sb.push_back(e);
    endtask

    task automatic idle_step(input string nm);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, nm);
    endtask

    // Monitor: compare one queued expectation after every rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check(mon_e);
            end
        end
    end

    // Stimulus
    initial begin
        rst_e.name  = "reset_values";
        rst_e.count = '0;
        rst_e.busy  = 1'b0;
        rst_e.ready = 1'b1;
        rst_e.tc    = 1'b0;
        rst_e.done  = 1'b0;

        #1 reset = 1'b0;
        #11;
        check(rst_e);
        @(negedge clk);
        reset = 1'b1;

        // One-shot, load 5; inputs scrambled during RUN must not matter
        step(1'b1, 5, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0, "os5_e0");
        for (int i = 4; i >= 0; i--)
            step(1'b0, 9, 1'b1, 1'b0, 1'b0, i, 1'b1, 1'b0, 1'b0, 1'b0, "os5_run");
        step(1'b0, 9, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, "os5_tc_done");
        idle_step("os5_idle");
        idle_step("os5_idle2");

        // Periodic, load 2, then abort
        step(1'b1, 2, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, "per_e0");
        step(1'b0, 7, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, "per_e1");
        step(1'b0, 7, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, "per_e2");
        step(1'b0, 7, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1, 1'b0, "per_tc1");
        step(1'b0, 7, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, "per_e4");
        step(1'b0, 7, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, "per_e5");
        step(1'b0, 7, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1, 1'b0, "per_tc2");
        step(1'b0, 7, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, "per_e7");
        step(1'b0, 7, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, "per_abort");
        idle_step("per_idle");

        // Pause two cycles at count 2, with start pulses during RUN
        step(1'b1, 3, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, "pz_e0");
        step(1'b0, 3, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, "pz_e1");
        step(1'b1, 7, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, "pz_hold1");
        step(1'b0, 7, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, "pz_hold2");
        step(1'b1, 7, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, "pz_e4");
        step(1'b0, 7, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, "pz_e5");
        step(1'b0, 7, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, "pz_tc_done");
        idle_step("pz_idle");

        // load 0 one-shot; abort in DONE has no effect
        step(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, "z_e0");
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, "z_tc_done");
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, "z_done_abort");

        // load 0 one-shot aborted the cycle after start
        step(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, "za_e0");
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, "za_abort");
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, "za_idle");

        // abort is ignored in IDLE: start with abort high still launches
        step(1'b1, 1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, "ia_e0");
        step(1'b0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, "ia_e1");
        step(1'b0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, "ia_tc_done");
        idle_step("ia_idle");

        // Asynchronous reset mid-RUN at count 4
        step(1'b1, 8, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b0, 1'b0, "ar_e0");
        for (int i = 7; i >= 4; i--)
            step(1'b0, 8, 1'b0, 1'b0, 1'b0, i, 1'b1, 1'b0, 1'b0, 1'b0, "ar_run");
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        rst_e.name = "async_reset";
        check(rst_e);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Full-scale count after reset release: 15 down to 0 without wrap
        step(1'b1, 15, 1'b0, 1'b0, 1'b0, 15, 1'b1, 1'b0, 1'b0, 1'b0, "f15_e0");
        for (int i = 14; i >= 0; i--)
            step(1'b0, 15, 1'b0, 1'b0, 1'b0, i, 1'b1, 1'b0, 1'b0, 1'b0, "f15_run");
        step(1'b0, 15, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, "f15_tc_done");
        idle_step("f15_idle");
        idle_step("f15_idle2");

        // Let the monitor drain, bounded
        for (int k = 0; k < 5 && sb.size() != 0; k++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
